ssd_scan_decoder: RTL and testbench
===================================

SSD_SCAN_DECODER -- requirements
Module: ssd_scan_decoder

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digit positions (2..8).
REQ-002 SHALL have parameter STABLE_CYCLES, default 16, consecutive identical samples required before decode (2..255).
REQ-003 SHALL have port clk  in  1  sole clock.
REQ-004 SHALL have port rst_n  in  1  reset; one clock; reset is synchronous and active-low.
REQ-005 SHALL have port an_n  in  NUM_DIGITS  active-low digit anode selects, asynchronous to clk.
REQ-006 SHALL have port seg_n  in  [0:6]  active-low segments, bit 0 = a ... bit 6 = g, asynchronous.
REQ-007 SHALL have port out_valid  out  1  decoded event available.
REQ-008 SHALL have port out_ready  in  1  consumer accepts the event.
REQ-009 SHALL have port out_idx  out  clog2(NUM_DIGITS)  digit position of the event.
REQ-010 SHALL have port out_val  out  4  decoded hex value.
REQ-011 SHALL have port out_err  out  1  pattern not a legal hex glyph.
REQ-012 SHALL have port digits  out  4*NUM_DIGITS  last legal value per position, digit 0 in bits [3:0].
REQ-013 SHALL have port ovf  out  1  sticky: an event was dropped.

Function
REQ-014 SHALL pass an_n and seg_n through a two-flop synchronizer; all further logic uses synchronized values.
REQ-015 SHALL decode active-low glyphs: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0001100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000; all other patterns are illegal.
REQ-016 SHALL implement FSM S_WAIT, S_COUNT, S_HELD; a sample is "qualified" when exactly one an_n bit is low.
REQ-017 S_WAIT: unqualified sample stays; qualified sample loads 8-bit counter with 1, goes S_COUNT.
REQ-018 S_COUNT: sample differing from previous, or unqualified, returns to S_WAIT (or restarts count at 1 if qualified); identical sample increments; on reaching STABLE_CYCLES performs capture and goes S_HELD.
REQ-019 S_HELD: remains while sample identical; any change behaves as S_WAIT entry in the same cycle.
REQ-020 Capture: legal glyph whose value differs from digits[idx], or first capture of idx since reset, SHALL update digits[idx] and generate an event; unchanged value SHALL generate nothing.
REQ-021 SHALL hold one event in a single-entry output register; out_idx/out_val/out_err stable while out_valid=1 and out_ready=0.
REQ-022 Transfer occurs on clk edge with out_valid=1 and out_ready=1; a capture in that same cycle SHALL load the register and keep out_valid=1.
REQ-023 Event arriving while register full and not transferring SHALL be dropped, set ovf; digits[] still updates.
REQ-024 ovf SHALL clear only by reset.
REQ-025 Capture-to-out_valid latency SHALL be 1 cycle; pin change to earliest out_valid = 2 + STABLE_CYCLES cycles.

Reset
REQ-026 With rst_n=0 at a clk edge: FSM S_WAIT, counter 0, synchronizers all-ones, out_valid 0, out_idx 0, out_val 0, out_err 0, digits 0, ovf 0, per-digit "seen" flags 0.
REQ-027 Reset asserted mid-count or with pending event SHALL discard all state; no event emitted after release until a new full stability window.

Configuration
REQ-028 Macro SSD_DEC_ERR_EN defined: stable illegal pattern generates an event with out_err=1, out_val=0, digits[] unchanged, then S_HELD.
REQ-029 Macro undefined: illegal patterns generate no event; out_err tied 0.

Structure
REQ-030 Package ssd_pkg SHALL hold the 16 glyph constants, FSM state typedef, and SEG_W=7.
REQ-031 Combinational sub-module ssd_seg2hex (seg_n in; val, legal out) SHALL perform the table decode.

Verification
REQ-032 an_n=1110, seg_n=0100100 held 30 cycles -> one event idx 0, val 5, err 0; digits[3:0]=5.
REQ-033 Same digit held, then seg_n toggles 1 cycle to 0000000 and back -> no event (window < STABLE_CYCLES).
REQ-034 Scan 4 digits "1A0F", 20 cycles each, out_ready=1, repeat twice -> exactly 4 events, second scan silent, digits=0xF0A1.
REQ-035 out_ready=0, two distinct captures -> first event held unchanged, second dropped, ovf=1, digits holds both.
REQ-036 an_n=1100 (two low) held 40 cycles -> no event; with SSD_DEC_ERR_EN, an_n=1101, seg_n=1111111 held -> event idx 1, err 1, val 0.
REQ-037 rst_n=0 at count 10 of 16 -> all outputs reset values; after release, event only after a fresh full window.

Source files
------------

// File: rtl/ssd_pkg.sv
// ssd_pkg: shared definitions for the seven-segment scan decoder.
//   SEG_W      - number of segment lines (a..g)
//   seg_t      - segment vector, index 0 = segment a ... index 6 = segment g
//   GLYPH_0..F - active-low glyph patterns, written left to right as a..g
//   state_t    - stability tracker FSM states
package ssd_pkg;

    localparam int SEG_W = 7;

    typedef logic [0:SEG_W-1] seg_t;

    localparam seg_t GLYPH_0 = 7'b0000001;
    localparam seg_t GLYPH_1 = 7'b1001111;
    localparam seg_t GLYPH_2 = 7'b0010010;
    localparam seg_t GLYPH_3 = 7'b0000110;
    localparam seg_t GLYPH_4 = 7'b1001100;
    localparam seg_t GLYPH_5 = 7'b0100100;
    localparam seg_t GLYPH_6 = 7'b0100000;
    localparam seg_t GLYPH_7 = 7'b0001111;
    localparam seg_t GLYPH_8 = 7'b0000000;
    localparam seg_t GLYPH_9 = 7'b0001100;
    localparam seg_t GLYPH_A = 7'b0001000;
    localparam seg_t GLYPH_B = 7'b1100000;
    localparam seg_t GLYPH_C = 7'b0110001;
    localparam seg_t GLYPH_D = 7'b1000010;
    localparam seg_t GLYPH_E = 7'b0110000;
    localparam seg_t GLYPH_F = 7'b0111000;

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_COUNT = 2'd1,
        S_HELD  = 2'd2
    } state_t;

endpackage

// File: rtl/ssd_seg2hex.sv
// ssd_seg2hex: combinational glyph decoder.
//   seg_n - active-low segment pattern (index 0 = a)
//   val   - hex value of the glyph (0 when not legal)
//   legal - pattern is one of the sixteen hex glyphs
module ssd_seg2hex
    import ssd_pkg::*;
(
    input  logic [0:SEG_W-1] seg_n,
    output logic [3:0]       val,
    output logic             legal
);

    always_comb begin
        val   = 4'h0;
        legal = 1'b1;
        case (seg_n)
            GLYPH_0: val = 4'h0;
            GLYPH_1: val = 4'h1;
            GLYPH_2: val = 4'h2;
            GLYPH_3: val = 4'h3;
            GLYPH_4: val = 4'h4;
            GLYPH_5: val = 4'h5;
            GLYPH_6: val = 4'h6;
            GLYPH_7: val = 4'h7;
            GLYPH_8: val = 4'h8;
            GLYPH_9: val = 4'h9;
            GLYPH_A: val = 4'hA;
            GLYPH_B: val = 4'hB;
            GLYPH_C: val = 4'hC;
            GLYPH_D: val = 4'hD;
            GLYPH_E: val = 4'hE;
            GLYPH_F: val = 4'hF;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/ssd_scan_decoder.sv
// ssd_scan_decoder: snoops a multiplexed seven-segment display bus and turns
// stable digit glyphs into value-change events.
//   clk, rst_n        - clock, synchronous active-low reset
//   an_n, seg_n       - asynchronous anode selects / segments (active low)
//   out_valid/ready   - single-entry event handshake
//   out_idx, out_val  - digit position and hex value of the event
//   out_err           - event reports an illegal glyph
//   digits            - last legal value per position, digit 0 in [3:0]
//   ovf               - sticky flag: an event was dropped
// Optional build macro SSD_DEC_ERR_EN: stable illegal glyphs raise an event
// with out_err=1; without it illegal glyphs are ignored and out_err is 0.
module ssd_scan_decoder
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_DIGITS-1:0]         an_n,
    input  logic [0:SEG_W-1]              seg_n,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(NUM_DIGITS)-1:0] out_idx,
    output logic [3:0]                    out_val,
    output logic                          out_err,
    output logic [4*NUM_DIGITS-1:0]       digits,
    output logic                          ovf
);

    localparam int         IDX_W    = $clog2(NUM_DIGITS);
    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

    logic [NUM_DIGITS-1:0] an_meta_reg, an_sync_reg, an_prev_reg;
    seg_t                  seg_meta_reg, seg_sync_reg, seg_prev_reg;
    state_t                state_reg;
    logic [7:0]            cnt_reg;
    logic [3:0]            digit_reg [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] seen_reg;
    logic                  out_valid_reg;
    logic [IDX_W-1:0]      out_idx_reg;
    logic [3:0]            out_val_reg;
    logic                  ovf_reg;

    logic [3:0]       low_cnt;
    logic [IDX_W-1:0] sel_idx;
    logic             qualified, same, cap_fire, known, dig_upd, ev_fire;
    logic [3:0]       dec_val, ev_val;
    logic             dec_legal;

    ssd_seg2hex u_dec (
        .seg_n (seg_sync_reg),
        .val   (dec_val),
        .legal (dec_legal)
    );

    // A sample is usable only when exactly one anode is driven.
    always_comb begin
        low_cnt = 4'd0;
        sel_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an_sync_reg[i]) begin
                low_cnt = low_cnt + 4'd1;
                sel_idx = IDX_W'(i);
            end
        end
        qualified = (low_cnt == 4'd1);
    end

    assign same     = (an_sync_reg == an_prev_reg) && (seg_sync_reg == seg_prev_reg);
    // The STABLE_CYCLES-th identical sample completes the window.
    assign cap_fire = (state_reg == S_COUNT) && same && (cnt_reg == CNT_LAST);
    assign known    = seen_reg[sel_idx] && (digit_reg[sel_idx] == dec_val);
    assign dig_upd  = cap_fire && dec_legal && !known;

`ifdef SSD_DEC_ERR_EN
    logic ev_err, out_err_reg;
    assign ev_fire = dig_upd || (cap_fire && !dec_legal);
    assign ev_val  = dec_legal ? dec_val : 4'h0;
    assign ev_err  = !dec_legal;
    assign out_err = out_err_reg;
`else
    assign ev_fire = dig_upd;
    assign ev_val  = dec_val;
    assign out_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an_meta_reg   <= '1;
            an_sync_reg   <= '1;
            an_prev_reg   <= '1;
            seg_meta_reg  <= '1;
            seg_sync_reg  <= '1;
            seg_prev_reg  <= '1;
            state_reg     <= S_WAIT;
            cnt_reg       <= 8'd0;
            seen_reg      <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) digit_reg[i] <= 4'h0;
            out_valid_reg <= 1'b0;
            out_idx_reg   <= '0;
            out_val_reg   <= 4'h0;
            ovf_reg       <= 1'b0;
`ifdef SSD_DEC_ERR_EN
            out_err_reg   <= 1'b0;
`endif
        end else begin
            an_meta_reg  <= an_n;
            an_sync_reg  <= an_meta_reg;
            an_prev_reg  <= an_sync_reg;
            seg_meta_reg <= seg_n;
            seg_sync_reg <= seg_meta_reg;
            seg_prev_reg <= seg_sync_reg;

            // Any change restarts tracking as if freshly entering from S_WAIT.
            case (state_reg)
                S_COUNT: begin
                    if (same) begin
                        cnt_reg <= cnt_reg + 8'd1;
                        if (cnt_reg == CNT_LAST) state_reg <= S_HELD;
                    end else if (qualified) begin
                        cnt_reg <= 8'd1;
                    end else begin
                        cnt_reg   <= 8'd0;
                        state_reg <= S_WAIT;
                    end
                end
                S_HELD: begin
                    if (!same) begin
                        if (qualified) begin
                            cnt_reg   <= 8'd1;
                            state_reg <= S_COUNT;
                        end else begin
                            cnt_reg   <= 8'd0;
                            state_reg <= S_WAIT;
                        end
                    end
                end
                default: begin
                    if (qualified) begin
                        cnt_reg   <= 8'd1;
                        state_reg <= S_COUNT;
                    end
                end
            endcase

            if (dig_upd) begin
                digit_reg[sel_idx] <= dec_val;
                seen_reg[sel_idx]  <= 1'b1;
            end

            // A new event may replace one leaving this same edge.
            if (ev_fire) begin
                if (!out_valid_reg || out_ready) begin
                    out_valid_reg <= 1'b1;
                    out_idx_reg   <= sel_idx;
                    out_val_reg   <= ev_val;
`ifdef SSD_DEC_ERR_EN
                    out_err_reg   <= ev_err;
`endif
                end else begin
                    ovf_reg <= 1'b1;
                end
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digits
            assign digits[gi*4 +: 4] = digit_reg[gi];
        end
    endgenerate

    assign out_valid = out_valid_reg;
    assign out_idx   = out_idx_reg;
    assign out_val   = out_val_reg;
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// tb_ssd_scan_decoder: directed scenarios followed by random scanning, all
// checked cycle by cycle against a behavioural model of the decoder.
module tb_ssd_scan_decoder;

    localparam int ND = 4;
    localparam int SC = 16;

    logic        clk;
    logic        rst_n;
    logic [3:0]  an_n;
    logic [0:6]  seg_n;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_idx;
    logic [3:0]  out_val;
    logic        out_err;
    logic [15:0] digits;
    logic        ovf;

    ssd_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .an_n      (an_n),
        .seg_n     (seg_n),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_val   (out_val),
        .out_err   (out_err),
        .digits    (digits),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [0:6] gl [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                            7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                            7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
                            7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    int vectors = 0;
    int miscompares = 0;
    int n_obs = 0;

    // Model: decoder sees pins two cycles late, counts identical samples,
    // and owns one output slot.
    logic [10:0] m_pipe1, m_pipe2, m_prev;
    int          m_run;
    logic        m_seen [4];
    logic [3:0]  m_dig [4];
    logic        m_valid, m_err, m_ovf;
    logic [1:0]  m_idx;
    logic [3:0]  m_val;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [10:0] s;
        logic [3:0]  a;
        logic [0:6]  sg;
        logic        ev, ev_err, legal;
        logic [3:0]  ev_val, v;
        logic [1:0]  ix;
        if (!rst_n) begin
            m_pipe1 = '1; m_pipe2 = '1; m_prev = '1; m_run = 0;
            for (int i = 0; i < 4; i++) begin m_seen[i] = 1'b0; m_dig[i] = 4'h0; end
            m_valid = 1'b0; m_idx = 2'd0; m_val = 4'h0; m_err = 1'b0; m_ovf = 1'b0;
            return;
        end
        s = m_pipe2;
        m_pipe2 = m_pipe1;
        m_pipe1 = {an_n, seg_n};
        if (s == m_prev) m_run++; else m_run = 1;
        m_prev = s;
        a = s[10:7];
        sg = s[6:0];
        ev = 1'b0; ev_err = 1'b0; ev_val = 4'h0; ix = 2'd0;
        if ($countones(~a) == 1 && m_run == SC) begin
            for (int i = 0; i < 4; i++) if (!a[i]) ix = 2'(i);
            legal = 1'b0; v = 4'h0;
            for (int i = 0; i < 16; i++) if (sg == gl[i]) begin legal = 1'b1; v = 4'(i); end
            if (legal) begin
                if (!m_seen[ix] || m_dig[ix] != v) begin
                    m_seen[ix] = 1'b1; m_dig[ix] = v;
                    ev = 1'b1; ev_val = v;
                end
            end else begin
`ifdef SSD_DEC_ERR_EN
                ev = 1'b1; ev_err = 1'b1;
`endif
            end
        end
        if (ev) begin
            if (!m_valid || out_ready) begin
                m_valid = 1'b1; m_idx = ix; m_val = ev_val; m_err = ev_err;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic check_cycle();
        logic [15:0] ed;
        for (int i = 0; i < 4; i++) ed[i*4 +: 4] = m_dig[i];
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) chk("event", 32'({out_idx, out_val, out_err}), 32'({m_idx, m_val, m_err}));
        chk("digits", 32'(digits), 32'(ed));
        chk("ovf", 32'(ovf), 32'(m_ovf));
    endtask

    task automatic tick();
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            n_obs++;
            $display("xfer idx=%0d val=%h err=%0d", out_idx, out_val, out_err);
        end
        model_edge();
        @(posedge clk);
        #1;
        check_cycle();
    endtask

    task automatic hold(input logic [3:0] a, input logic [0:6] s, input int n);
        an_n = a;
        seg_n = s;
        repeat (n) tick();
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (out_valid !== 1'b1 && n < 60);
    endtask

    initial begin
        int lat, mark;
        rst_n = 1'b0; an_n = 4'hF; seg_n = 7'b1111111; out_ready = 1'b1;
        repeat (3) tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_digits", 32'(digits), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_err", 32'(out_err), 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Single stable digit, latency from pin change.
        mark = n_obs;
        an_n = 4'b1110; seg_n = gl[5];
        wait_valid(lat);
        chk("lat_first", 32'(lat), 32'(SC + 2));
        repeat (12) tick();
        chk("ev_single", 32'(n_obs - mark), 32'd1);
        chk("dig0_five", 32'(digits[3:0]), 32'd5);

        // One-cycle glitch to 8 and back: nothing new.
        mark = n_obs;
        hold(4'b1110, gl[8], 1);
        hold(4'b1110, gl[5], 30);
        chk("ev_glitch", 32'(n_obs - mark), 32'd0);

        // Scan "1A0F" twice.
        mark = n_obs;
        for (int p = 0; p < 2; p++) begin
            hold(4'b1110, gl[1], 20);
            hold(4'b1101, gl[10], 20);
            hold(4'b1011, gl[0], 20);
            hold(4'b0111, gl[15], 20);
        end
        hold(4'hF, gl[8], 4);
        chk("ev_scan", 32'(n_obs - mark), 32'd4);
        chk("dig_scan", 32'(digits), 32'hF0A1);

        // Consumer stalled: second event dropped.
        out_ready = 1'b0;
        mark = n_obs;
        hold(4'b1110, gl[7], 20);
        hold(4'b1101, gl[3], 20);
        hold(4'hF, gl[8], 4);
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_event", 32'({out_idx, out_val}), 32'({2'd0, 4'h7}));
        chk("stall_ovf", 32'(ovf), 32'd1);
        chk("stall_digits", 32'(digits[7:0]), 32'h37);
        out_ready = 1'b1;
        repeat (2) tick();
        chk("stall_xfer", 32'(n_obs - mark), 32'd1);

        // Two anodes low, then illegal glyph on a single anode.
        mark = n_obs;
        hold(4'b1100, gl[5], 40);
        chk("ev_twolow", 32'(n_obs - mark), 32'd0);
        hold(4'b1101, 7'b1111111, 20);
        hold(4'hF, gl[8], 4);
`ifdef SSD_DEC_ERR_EN
        chk("ev_illegal", 32'(n_obs - mark), 32'd1);
`else
        chk("ev_illegal", 32'(n_obs - mark), 32'd0);
`endif

        // Reset mid-count with an event pending.
        out_ready = 1'b0;
        hold(4'b0111, gl[14], 20);
        hold(4'b1011, gl[9], 11);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_digits", 32'(digits), 32'd0);
        chk("mid_rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        mark = n_obs;
        wait_valid(lat);
        chk("lat_after_rst", 32'(lat), 32'(SC + 2));
        repeat (4) tick();
        chk("ev_after_rst", 32'(n_obs - mark), 32'd1);
        chk("dig2_nine", 32'(digits[11:8]), 32'd9);

        // Random scanning with random back-pressure and occasional reset.
        for (int h = 0; h < 300; h++) begin
            int len;
            logic [3:0] a;
            logic [0:6] s;
            if ($urandom % 5 != 0) a = ~(4'b0001 << ($urandom % 4));
            else a = 4'($urandom);
            if ($urandom % 4 != 0) s = gl[$urandom % 16];
            else s = 7'($urandom);
            len = $urandom_range(1, 24);
            an_n = a; seg_n = s;
            if ($urandom % 50 == 0) begin
                rst_n = 1'b0;
                repeat (2) tick();
                rst_n = 1'b1;
            end
            for (int k = 0; k < len; k++) begin
                out_ready = ($urandom % 4 != 0);
                tick();
            end
        end
        out_ready = 1'b1;
        hold(4'hF, gl[8], 6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
